// File: rtl/mm_activation_buffer.sv
// mm_activation_buffer
//   Downstream stage of the 2x2*2x1 FP matrix-multiply datapath. It accepts
//   result vectors (c1, c2, exceptions) over a valid/ready handshake and
//   applies an element-wise ReLU before storing them. Results are queued in a
//   small first-word-fall-through FIFO for the next layer. A sticky exception
//   summary and a wrapping count of accepted vectors are kept for status.
//
//   Optional feature macro: LEAKY_RELU_EN
//     Defined   : negative finite values are scaled by 2^-LEAK_SHIFT by
//                 adjusting the exponent. Values that would underflow become
//                 +0. -inf and NaN pass through unchanged.
//     Undefined : plain ReLU; LEAK_SHIFT is unused.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_c1, in_c2       matmul result rows (W = exp_width + mant_width bits)
//   in_exceptions      5-bit matmul exception flags
//   out_valid/out_ready output handshake
//   out_y1, out_y2     activated rows from the FIFO head
//   out_exceptions     exception flags stored with the head entry
//   out_clipped        [1]=y2, [0]=y1: activation changed the value
//   sticky_exceptions  OR of accepted exception flags since reset/clear
//   sticky_clr         clears sticky_exceptions
//   sample_count       number of accepted vectors (wraps)
module mm_activation_buffer #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [exp_width+mant_width-1:0]      in_c1,
  input  logic [exp_width+mant_width-1:0]      in_c2,
  input  logic [4:0]                           in_exceptions,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [exp_width+mant_width-1:0]      out_y1,
  output logic [exp_width+mant_width-1:0]      out_y2,
  output logic [4:0]                           out_exceptions,
  output logic [1:0]                           out_clipped,
  output logic [4:0]                           sticky_exceptions,
  input  logic                                 sticky_clr,
  output logic [CNT_WIDTH-1:0]                 sample_count
);

  localparam int W  = exp_width + mant_width;
  localparam int FW = mant_width - 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [4:0]   exc;
    logic [1:0]   clip;
  } entry_t;

  // Returns {clipped, value}.
  function automatic logic [W:0] activate(input logic [W-1:0] x);
    logic                 sign;
    logic [exp_width-1:0] e;
    logic [FW-1:0]        f;
    logic                 is_nan;
    logic [W:0]           r;
    sign   = x[W-1];
    e      = x[W-2:FW];
    f      = x[FW-1:0];
    is_nan = (&e) && (f != '0);
    r      = {1'b0, x};
`ifdef LEAKY_RELU_EN
    // -inf (exponent all ones, fraction zero) is left alone like NaN.
    if (sign && !(&e)) begin
      if (e > exp_width'(LEAK_SHIFT))
        r = {1'b1, 1'b1, e - exp_width'(LEAK_SHIFT), f};
      else
        r = {1'b1, {W{1'b0}}};  // would underflow into subnormal range
    end
`else
    if (sign && !is_nan)
      r = {1'b1, {W{1'b0}}};
`endif
    return r;
  endfunction

  entry_t               mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic [4:0]           sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] sample_q, sample_d;

  logic   accept, pop;
  logic [W:0] act1, act2;
  entry_t new_entry, head;

  assign in_ready  = (count_q != (AW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign act1      = activate(in_c1);
  assign act2      = activate(in_c2);
  assign new_entry = '{y1: act1[W-1:0], y2: act2[W-1:0], exc: in_exceptions,
                       clip: {act2[W], act1[W]}};

  // First-word fall-through: outputs read the head slot directly.
  assign head           = mem_q[rd_ptr_q];
  assign out_y1         = head.y1;
  assign out_y2         = head.y2;
  assign out_exceptions = head.exc;
  assign out_clipped    = head.clip;

  assign sticky_exceptions = sticky_q;
  assign sample_count      = sample_q;

  always_comb begin
    count_d = count_q;
    if (accept && !pop)
      count_d = count_q + 1'b1;
    else if (!accept && pop)
      count_d = count_q - 1'b1;
    // A clear in the same cycle as an accept keeps the new flags.
    sticky_d = (sticky_clr ? 5'b0 : sticky_q) | (accept ? in_exceptions : 5'b0);
    sample_d = sample_q + CNT_WIDTH'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
      sample_q <= '0;
      // Storage is cleared so the head reads zero right after reset.
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_mm_activation_buffer.sv
module tb_mm_activation_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;
  localparam int LEAK  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_c1 = '0;
  logic [W-1:0]    in_c2 = '0;
  logic [4:0]      in_exceptions = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_y1;
  logic [W-1:0]    out_y2;
  logic [4:0]      out_exceptions;
  logic [1:0]      out_clipped;
  logic [4:0]      sticky_exceptions;
  logic            sticky_clr = 1'b0;
  logic [CNTW-1:0] sample_count;

  mm_activation_buffer #(
    .exp_width(8), .mant_width(24), .DEPTH(DEPTH), .CNT_WIDTH(CNTW),
    .LEAK_SHIFT(LEAK)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c1(in_c1), .in_c2(in_c2), .in_exceptions(in_exceptions),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y1(out_y1), .out_y2(out_y2),
    .out_exceptions(out_exceptions), .out_clipped(out_clipped),
    .sticky_exceptions(sticky_exceptions), .sticky_clr(sticky_clr),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [4:0]   exc;
    logic [1:0]   clip;
  } ent_t;

  ent_t            mq[$];
  logic [4:0]      m_sticky = '0;
  logic [CNTW-1:0] m_count  = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Activation rule stated on the IEEE-754 single-precision value.
  function automatic void ref_act(input logic [W-1:0] x, output logic [W-1:0] y,
                                  output logic clip);
    logic       neg;
    int         e;
    logic       is_nan, is_inf;
    neg    = x[31];
    e      = int'(x[30:23]);
    is_nan = (e == 255) && (x[22:0] != 0);
    is_inf = (e == 255) && (x[22:0] == 0);
    y = x;
    clip = 1'b0;
`ifdef LEAKY_RELU_EN
    if (neg && !is_nan && !is_inf) begin
      clip = 1'b1;
      if (e > LEAK) y = x - (W'(LEAK) << 23);  // divide by 2^LEAK
      else          y = '0;
    end
`else
    if (neg && !is_nan) begin
      y = '0;
      clip = 1'b1;
    end
`endif
  endfunction

  task automatic check_state();
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("sticky", sticky_exceptions, m_sticky);
    chk("sample_count", sample_count, m_count);
    if (mq.size() != 0) begin
      chk("out_y1", out_y1, mq[0].y1);
      chk("out_y2", out_y2, mq[0].y2);
      chk("out_exc", out_exceptions, mq[0].exc);
      chk("out_clipped", out_clipped, mq[0].clip);
    end
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] e, input logic r, input logic clr,
                      output logic accepted);
    logic acc, pp;
    ent_t n;
    check_state();
    in_valid = v; in_c1 = a; in_c2 = b; in_exceptions = e;
    out_ready = r; sticky_clr = clr;
    acc = v && (mq.size() != DEPTH);
    pp  = r && (mq.size() != 0);
    ref_act(a, n.y1, n.clip[0]);
    ref_act(b, n.y2, n.clip[1]);
    n.exc = e;
    @(posedge clk);
    if (pp) begin
      $display("pop  y1=%08h y2=%08h exc=%05b clip=%02b", mq[0].y1, mq[0].y2, mq[0].exc, mq[0].clip);
      void'(mq.pop_front());
    end
    if (acc) begin
      $display("push c1=%08h c2=%08h exc=%05b", a, b, e);
      mq.push_back(n);
      m_count++;
    end
    m_sticky = (clr ? 5'b0 : m_sticky) | (acc ? e : 5'b0);
    accepted = acc;
    @(negedge clk);
    in_valid = 1'b0; sticky_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    mq.delete(); m_sticky = '0; m_count = '0;
    $display("reset");
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", sample_count, '0);
    chk("rst_sticky", sticky_exceptions, '0);
    chk("rst_y1", out_y1, '0);
    chk("rst_y2", out_y2, '0);
    chk("rst_exc", out_exceptions, '0);
    chk("rst_clip", out_clipped, '0);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, a);
  endtask

  logic acc;
  logic [W-1:0] vec[5];

  initial begin
    @(negedge clk);
    do_reset();

    // Basic ReLU with one-cycle latency.
    step(1'b1, 32'h40400000, 32'hC0400000, 5'b0, 1'b1, 1'b0, acc);
    chk("lat_valid", out_valid, 1'b1);
    chk("basic_y1", out_y1, 32'h40400000);
`ifdef LEAKY_RELU_EN
    chk("basic_y2", out_y2, 32'hBEC00000);
`else
    chk("basic_y2", out_y2, 32'h00000000);
`endif
    chk("basic_clip", out_clipped, 2'b10);
    chk("basic_count", sample_count, 16'd1);
    drain();

    // NaN / -inf, then an underflowing negative value.
    step(1'b1, 32'hFFC00001, 32'hFF800000, 5'b0, 1'b0, 1'b0, acc);
    chk("nan_y1", out_y1, 32'hFFC00001);
    chk("nan_clip0", out_clipped[0], 1'b0);
`ifdef LEAKY_RELU_EN
    chk("inf_y2", out_y2, 32'hFF800000);
`else
    chk("inf_y2", out_y2, 32'h00000000);
`endif
    step(1'b1, 32'h40400000, 32'h81000000, 5'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
    chk("small_y2", out_y2, 32'h00000000);
    chk("small_clip1", out_clipped[1], 1'b1);
    drain();

    // Backpressure: five vectors, four fit.
    for (int i = 0; i < 5; i++) vec[i] = 32'h3F800000 + W'(i << 20);
    for (int i = 0; i < 5; i++) step(1'b1, vec[i], vec[i], 5'b0, 1'b0, 1'b0, acc);
    chk("bp_full", in_ready, 1'b0);
    chk("bp_head", out_y1, vec[0]);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, vec[4], vec[4], 5'b0, 1'b1, 1'b0, acc);
    chk("bp_v5_taken", acc, 1'b1);
    drain();

    // Sticky exceptions.
    step(1'b1, '0, '0, 5'b00100, 1'b1, 1'b0, acc);
    step(1'b1, '0, '0, 5'b00001, 1'b1, 1'b0, acc);
    chk("sticky_or", sticky_exceptions, 5'b00101);
    step(1'b1, '0, '0, 5'b10000, 1'b1, 1'b1, acc);
    chk("sticky_clr_acc", sticky_exceptions, 5'b10000);
    drain();

    // Reset with entries queued and a push in flight.
    for (int i = 0; i < 3; i++) step(1'b1, vec[i], vec[i], 5'b00010, 1'b0, 1'b0, acc);
    in_valid = 1'b1; in_c1 = vec[3]; in_c2 = vec[3];
    do_reset();
    drain();

    // Randomized traffic with a mix of special encodings.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = {a[31], 8'hFF, a[22:0]};
        1: b = {b[31], 8'h00, b[22:0]};
        2: a = {a[31], 8'hFF, 23'h0};
        3: b = {1'b1, 8'($urandom_range(0, 5)), b[22:0]};
        default: ;
      endcase
      step(1'($urandom_range(0, 3) != 0), a, b, 5'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0), acc);
    end
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
